inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: the inverse of the immediate generator.
- Accepts decoded fields (opcode, funct3, funct7, rd, rs1, rs2, signed immediate) and packs them into a 32-bit instruction word, scattering immediate bits per format.
- Range-checks each immediate, tags each word with a byte address, and streams results out for loading instruction memory (test/boot loader path).
- Two-stage valid/ready pipeline.

Parameters:
- ADDR_W, 10, byte-address width of out_addr.
- BASE_ADDR, 0, address loaded on reset/restart (multiple of 4).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  reloads the address counter and clears err_count; pipeline contents are kept.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept.
- in_opcode  in  7  opcode.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type and shift-immediate).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate; U-type uses upper-20 form.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- out_err  out  1  immediate out of range or opcode unsupported.
- err_count  out  8  saturating error counter.

Behaviour:
- Reset, synchronous and active-high: out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, err_count=0, both stage valids=0.
- in_ready=1 after reset.
- Stage A registers raw fields on in_valid&&in_ready.
- Stage B registers the encoded word plus err. It holds out_inst/out_addr/out_err.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput: 1 per cycle.
- Stall rule: stage B loads when !out_valid || out_ready. Stage A advances under the same condition.
- in_ready = !a_valid || (!out_valid || out_ready), a combinational path from out_ready.
- Outputs stay stable while out_valid && !out_ready.
- Transfer = out_valid&&out_ready.
  - On each transfer, out_addr advances by 4 for the next word, wrapping modulo 2^ADDR_W.
  - Addresses are assigned in order at stage-B load.
- Formats and checks:
  - I-load 0000011, I-arith 0010011, JALR 1100111: imm in [-2048, 2047].
  - Shift-immediate (0010011, funct3 001/101): imm in [0, 31]. inst[31:25]=in_funct7, inst[24:20]=imm[4:0].
  - S 0100011: imm in [-2048, 2047]. inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B 1100011: imm even, in [-4096, 4094]. inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J 1101111: imm even, in [-1048576, 1048574]. inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U 0110111/0010111: imm[11:0] must be 0. inst[31:12]=imm[31:12].
  - R 0110011: no immediate check; imm ignored.
- Fields not used by a format are encoded as 0 (e.g. rs2 for I-type, rd for S/B).
- Any other opcode → err.
- On err: out_inst = 32'h00000013 (NOP), out_err=1. The word still consumes an address so the memory layout is preserved.
- err_count increments on each err transfer and saturates at 255.
- Round-trip property: for every non-error word, feeding out_inst to the immediate generator reproduces in_imm (I/S/B/J/JALR/shift).
- restart and a transfer in the same cycle: restart wins, and out_addr=BASE_ADDR.
- Reset mid-stream: in-flight words are discarded; no partial output.

Decomposition:
- Package riscv_enc_pkg:
  - opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_REG);
  - NOP_INST;
  - enum fmt_e {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD}.
- Sub-module inst_pack: combinational; input fields and fmt_e; output inst and err. It contains all bit scattering and range checks.
- inst_encoder holds the pipeline, handshake and counters.

Test Plan:
- ADDI x1,x0,-1 (opcode 0010011, f3 000, rd 1, imm -1) → out_inst 0xFFF00093, out_err 0, out_addr 0x000, two cycles after acceptance.
- SW x2,8(x1) (0100011, f3 010, rs1 1, rs2 2, imm 8) → 0x0020A423.
- BEQ x0,x0,-4 → 0xFE000EE3.
- JAL x1,+2048 → 0x001000EF.
- SRAI x5,x5,3 (f3 101, f7 0100000) → 0x4032D293.
- ADDI imm 2048, then B imm 3, then opcode 1111111 → three words 0x00000013 with out_err=1 and err_count=3.
- Backpressure: 3 back-to-back inputs with out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts; outputs stay stable.
  - After release, the words appear in order at addresses 0x000, 0x004, 0x008.
- Wrap and restart: ADDR_W=4, 5 transfers → addresses 0, 4, 8, C, 0. Asserting restart → next address BASE_ADDR and err_count 0.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, the canonical NOP and the
// instruction-format classification used by the packer.
package riscv_enc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
    } fmt_e;

    // Shift-immediates share OP_IMM but carry funct7 and a 5-bit shamt.
    function automatic fmt_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
        fmt_e f;
        case (opcode)
            OP_LOAD, OP_JALR:  f = FMT_I;
            OP_IMM:            f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
            OP_STORE:          f = FMT_S;
            OP_BRANCH:         f = FMT_B;
            OP_JAL:            f = FMT_J;
            OP_LUI, OP_AUIPC:  f = FMT_U;
            OP_REG:            f = FMT_R;
            default:           f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: scatters immediate bits into the instruction word
// per format and flags out-of-range immediates or unsupported opcodes.
module inst_pack
    import riscv_enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic signed [31:0] simm;
    logic [31:0]        raw;
    logic               bad;

    assign simm = $signed(imm);

    always_comb begin
        raw = '0;
        bad = 1'b0;
        case (fmt)
            FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                raw = {imm[11:0], rs1, funct3, rd, opcode};
                bad = (simm < -2048) || (simm > 2047);
            end
            FMT_SH: begin
                raw = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                bad = (simm < 0) || (simm > 31);
            end
            FMT_S: begin
                raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                bad = (simm < -2048) || (simm > 2047);
            end
            FMT_B: begin
                raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                bad = imm[0] || (simm < -4096) || (simm > 4094);
            end
            FMT_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                bad = imm[0] || (simm < -1048576) || (simm > 1048574);
            end
            FMT_U: begin
                raw = {imm[31:12], rd, opcode};
                bad = (imm[11:0] != 12'd0);
            end
            default: bad = 1'b1;
        endcase
        // Rejected words become a NOP so the loaded image stays executable.
        inst = bad ? NOP_INST : raw;
        err  = bad;
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I encoder stream: raw fields in stage A,
// packed word plus error flag in stage B, byte address and error tally.
module inst_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic        a_valid;
    logic [6:0]  a_opcode, a_funct7;
    logic [2:0]  a_funct3;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_imm;
    fmt_e        a_fmt;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        load_b, xfer;

    assign load_b   = !out_valid || out_ready;
    assign in_ready = !a_valid || load_b;
    assign xfer     = out_valid && out_ready;
    assign a_fmt    = classify(a_opcode, a_funct3);

    inst_pack u_pack (
        .fmt    (a_fmt),
        .opcode (a_opcode),
        .funct3 (a_funct3),
        .funct7 (a_funct7),
        .rd     (a_rd),
        .rs1    (a_rs1),
        .rs2    (a_rs2),
        .imm    (a_imm),
        .inst   (enc_inst),
        .err    (enc_err)
    );

    // Stage A also fills while B is stalled, as long as A itself is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid  <= 1'b0;
            a_opcode <= '0;
            a_funct3 <= '0;
            a_funct7 <= '0;
            a_rd     <= '0;
            a_rs1    <= '0;
            a_rs2    <= '0;
            a_imm    <= '0;
        end else if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_opcode <= in_opcode;
                a_funct3 <= in_funct3;
                a_funct7 <= in_funct7;
                a_rd     <= in_rd;
                a_rs1    <= in_rs1;
                a_rs2    <= in_rs2;
                a_imm    <= in_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (load_b) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_inst <= enc_inst;
                out_err  <= enc_err;
            end
        end
    end

    // out_addr is the address of the word at the head of the stream; it only
    // moves on a transfer, so it stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            out_addr  <= BASE;
            err_count <= '0;
        end else if (xfer) begin
            out_addr <= out_addr + ADDR_W'(4);
            if (out_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, error handling,
// backpressure, address wrap/restart and a randomized scoreboard run.
module tb_inst_encoder;
    import riscv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, out_ready;
    logic [6:0]  in_opcode, in_funct7;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [9:0]  out_addr;
    logic [7:0]  err_count;
    logic        in_ready_w, out_valid_w, out_err_w;
    logic [31:0] out_inst_w;
    logic [3:0]  out_addr_w;
    logic [7:0]  err_count_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    // Narrow-address twin fed the same stream, used to observe wrap-around.
    inst_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_w (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_inst(out_inst_w),
        .out_addr(out_addr_w), .out_err(out_err_w), .err_count(err_count_w)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
    } exp_t;

    // Reference encoder built from the format tables with plain arithmetic.
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        int s;
        logic [31:0] w;
        bit bad;
        logic [31:0] regs_i, regs_sb;
        s = int'($signed(imm));
        bad = 0;
        w = 32'd0;
        regs_i  = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        regs_sb = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        if (op == 7'h03 || op == 7'h67 || (op == 7'h13 && f3 != 3'd1 && f3 != 3'd5)) begin
            bad = (s < -2048) || (s > 2047);
            w = ((imm & 32'hfff) << 20) | regs_i;
        end else if (op == 7'h13) begin
            bad = (s < 0) || (s > 31);
            w = (32'(f7) << 25) | ((imm & 32'h1f) << 20) | regs_i;
        end else if (op == 7'h23) begin
            bad = (s < -2048) || (s > 2047);
            w = (((imm >> 5) & 32'h7f) << 25) | ((imm & 32'h1f) << 7) | regs_sb;
        end else if (op == 7'h63) begin
            bad = (s % 2 != 0) || (s < -4096) || (s > 4094);
            w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) |
                (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7) | regs_sb;
        end else if (op == 7'h6f) begin
            bad = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
            w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
                (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12) |
                (32'(rd) << 7) | 32'(op);
        end else if (op == 7'h37 || op == 7'h17) begin
            bad = (imm & 32'hfff) != 32'd0;
            w = (imm & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
        end else if (op == 7'h33) begin
            w = (32'(f7) << 25) | regs_sb | (32'(rd) << 7);
        end else begin
            bad = 1;
        end
        if (bad) w = 32'h13;
        return {bad, w};
    endfunction

    // Immediate generator (decode direction) for the round-trip property.
    function automatic logic [31:0] dec_imm(input logic [31:0] i, input logic [6:0] op,
                                            input logic [2:0] f3);
        logic [31:0] v;
        case (op)
            7'h03, 7'h67: v = {{20{i[31]}}, i[31:20]};
            7'h13: v = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
            7'h23: v = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h6f: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            7'h37, 7'h17: v = {i[31:12], 12'd0};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Presents one word until accepted (bounded), then drops in_valid.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        bit ok;
        ok = 0;
        @(negedge clk);
        set_fields(op, f3, f7, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: in_ready never rose, required acceptance");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_word(output logic [31:0] inst, output logic [9:0] addr,
                            output logic [3:0] addr_w, output logic err, output bit ok);
        ok = 0; inst = '0; addr = '0; addr_w = '0; err = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                inst = out_inst; addr = out_addr; addr_w = out_addr_w; err = out_err;
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL get_word: out_valid never rose, required a word");
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b inst=%h err=%b, required 0/0/0", out_valid, out_inst, out_err);
        end
        checks++;
        if (out_addr !== 10'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: addr=%h errcnt=%0d, required 0/0", out_addr, err_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        @(negedge clk);
        set_fields(OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_accept: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'hFFF00093 || out_err !== 1'b0 || out_addr !== 10'h000) begin
            errors++;
            $display("FAIL lat_addi: valid=%b inst=%h err=%b addr=%h, required 1/fff00093/0/000",
                     out_valid, out_inst, out_err, out_addr);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] exp_inst [4];
        logic [31:0] inst; logic [9:0] a; logic [3:0] aw; logic e; bit ok;
        exp_inst[0] = 32'h0020A423; exp_inst[1] = 32'hFE000EE3;
        exp_inst[2] = 32'h001000EF; exp_inst[3] = 32'h4032D293;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: send(OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
                1: send(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
                2: send(OP_JAL, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
                default: send(OP_IMM, 3'b101, 7'b0100000, 5'd5, 5'd5, 5'd0, 32'd3);
            endcase
            get_word(inst, a, aw, e, ok);
            checks++;
            if (ok && (inst !== exp_inst[k] || e !== 1'b0)) begin
                errors++;
                $display("FAIL vector_%0d: inst=%h err=%b, required %h/0", k, inst, e, exp_inst[k]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] inst; logic [9:0] a; logic [3:0] aw; logic e; bit ok;
        out_ready = 1'b1;
        pulse_restart();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: send(OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
                1: send(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
                default: send(7'b1111111, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
            endcase
            get_word(inst, a, aw, e, ok);
            checks++;
            if (ok && (inst !== 32'h00000013 || e !== 1'b1 || a !== 10'(4 * k))) begin
                errors++;
                $display("FAIL err_word_%0d: inst=%h err=%b addr=%h, required 00000013/1/%h", k, inst, e, a, 10'(4 * k));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (err_count !== 8'd3) begin
            errors++;
            $display("FAIL err_count: got %0d, required 3", err_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [3];
        logic [31:0] held;
        int n_acc, n_got;
        words[0] = 32'h00A00093; words[1] = 32'h01400113; words[2] = 32'h01E00193;
        pulse_restart();
        out_ready = 1'b0;
        n_acc = 0;
        held = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (n_acc < 3) begin
                set_fields(OP_IMM, 3'b000, 7'd0, 5'(n_acc + 1), 5'd0, 5'd0, 32'(10 * (n_acc + 1)));
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (cyc == 2) held = out_inst;
            if (cyc >= 2) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== words[0] || out_inst !== held) begin
                    errors++;
                    $display("FAIL bp_stall_%0d: in_ready=%b valid=%b inst=%h, required 0/1/%h",
                             cyc, in_ready, out_valid, out_inst, words[0]);
                end
            end
            if (in_valid && in_ready) n_acc++;
        end
        checks++;
        if (n_acc != 2) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepts while stalled, required 2", n_acc);
        end
        n_got = 0;
        for (int cyc = 0; cyc < 30 && n_got < 3; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (n_acc < 3) begin
                set_fields(OP_IMM, 3'b000, 7'd0, 5'(n_acc + 1), 5'd0, 5'd0, 32'(10 * (n_acc + 1)));
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if (out_inst !== words[n_got] || out_addr !== 10'(4 * n_got)) begin
                    errors++;
                    $display("FAIL bp_order_%0d: inst=%h addr=%h, required %h/%h",
                             n_got, out_inst, out_addr, words[n_got], 10'(4 * n_got));
                end
                n_got++;
            end
            if (in_valid && in_ready) n_acc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n_got != 3) begin
            errors++;
            $display("FAIL bp_drain: got %0d words, required 3", n_got);
        end
    endtask

    task automatic test_wrap_restart();
        logic [31:0] inst; logic [9:0] a; logic [3:0] aw; logic e; bit ok;
        out_ready = 1'b1;
        pulse_restart();
        for (int k = 0; k < 5; k++) begin
            send(OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k));
            get_word(inst, a, aw, e, ok);
            checks++;
            if (ok && aw !== 4'((4 * k) % 16)) begin
                errors++;
                $display("FAIL wrap_addr_%0d: got %h, required %h", k, aw, 4'((4 * k) % 16));
            end
        end
        // An error word transferring in the same cycle as restart: restart wins.
        send(7'b0001011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        get_word(inst, a, aw, e, ok);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        #1;
        checks++;
        if (out_addr_w !== 4'd0 || out_addr !== 10'd0 || err_count !== 8'd0 || err_count_w !== 8'd0) begin
            errors++;
            $display("FAIL restart: addr=%h addr_w=%h errcnt=%0d/%0d, required 0/0/0/0",
                     out_addr, out_addr_w, err_count, err_count_w);
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b0;
        send(OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(OP_IMM, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || out_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_midstream: %0d words emerged, addr=%h, required 0/000", seen, out_addr);
        end
    endtask

    task automatic gen(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7,
                       output logic [4:0] rd, output logic [4:0] rs1, output logic [4:0] rs2,
                       output logic [31:0] imm);
        int k, s;
        bit oor;
        k = int'($urandom_range(0, 8));
        oor = ($urandom_range(0, 7) == 0);
        f3 = 3'($urandom); f7 = 7'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        s = 0;
        op = OP_REG;
        if (oor) begin
            s = 2048 + int'($urandom_range(0, 5000));
            if ($urandom_range(0, 1) == 1) s = -s - 1;
        end
        case (k)
            0, 1: begin
                op = (k == 0) ? OP_LOAD : (($urandom_range(0, 1) == 1) ? OP_IMM : OP_JALR);
                if (op == OP_IMM && (f3 == 3'd1 || f3 == 3'd5)) f3 = 3'd0;
                if (!oor) s = int'($urandom_range(0, 4095)) - 2048;
            end
            2: begin
                op = OP_IMM; f3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
                s = oor ? ((s > 0) ? 32 + (s % 64) : -1 - (-s % 64)) : int'($urandom_range(0, 31));
            end
            3: begin op = OP_STORE; if (!oor) s = int'($urandom_range(0, 4095)) - 2048; end
            4: begin
                op = OP_BRANCH;
                if (oor) s = ($urandom_range(0, 1) == 1) ? 4096 : 2 * int'($urandom_range(0, 100)) + 1;
                else s = 2 * int'($urandom_range(0, 4095)) - 4096;
            end
            5: begin
                op = OP_JAL;
                if (oor) s = ($urandom_range(0, 1) == 1) ? 1048576 : 2 * int'($urandom_range(0, 1000)) + 1;
                else s = 2 * int'($urandom_range(0, 1048575)) - 1048576;
            end
            6: begin
                op = ($urandom_range(0, 1) == 1) ? OP_LUI : OP_AUIPC;
                s = int'({$urandom_range(0, 32'hFFFFF), 12'd0});
                if (oor) s = s | int'($urandom_range(1, 4095));
            end
            7: begin op = OP_REG; s = int'($urandom); end
            default: begin
                case ($urandom_range(0, 3))
                    0: op = 7'h7F;
                    1: op = 7'h0F;
                    2: op = 7'h73;
                    default: op = 7'h2B;
                endcase
                s = int'($urandom);
            end
        endcase
        imm = 32'(s);
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t ex;
        logic [32:0] r;
        logic [9:0] addr_m;
        int errc_m, guard;
        bit pend;
        logic [6:0] op, f7; logic [2:0] f3; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
        pulse_restart();
        addr_m = 10'd0; errc_m = 0; pend = 0;
        op = '0; f3 = '0; f7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        guard = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc < 500 && !pend && $urandom_range(0, 3) != 0) begin
                gen(op, f3, f7, rd, rs1, rs2, imm);
                pend = 1;
            end
            set_fields(op, f3, f7, rd, rs1, rs2, imm);
            in_valid = pend;
            out_ready = (cyc >= 500) || ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: unexpected word %h, required none", out_inst);
                end else begin
                    ex = q.pop_front();
                    if (out_inst !== ex.inst || out_err !== ex.err || out_addr !== addr_m ||
                        out_addr_w !== addr_m[3:0] || err_count !== 8'(errc_m)) begin
                        errors++;
                        $display("FAIL rnd_word: inst=%h err=%b addr=%h errcnt=%0d, required %h/%b/%h/%0d",
                                 out_inst, out_err, out_addr, err_count, ex.inst, ex.err, addr_m, errc_m);
                    end
                    if (!ex.err && ex.op != OP_REG) begin
                        checks++;
                        if (dec_imm(out_inst, ex.op, ex.f3) !== ex.imm) begin
                            errors++;
                            $display("FAIL rnd_roundtrip: decoded %h, required %h",
                                     dec_imm(out_inst, ex.op, ex.f3), ex.imm);
                        end
                    end
                    addr_m = addr_m + 10'd4;
                    if (ex.err && errc_m < 255) errc_m++;
                end
            end
            if (in_valid && in_ready) begin
                r = ref_enc(op, f3, f7, rd, rs1, rs2, imm);
                ex.inst = r[31:0]; ex.err = r[32]; ex.op = op; ex.f3 = f3; ex.imm = imm;
                q.push_back(ex);
                pend = 0;
            end
            guard = cyc;
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d words outstanding after %0d cycles, required 0", q.size(), guard);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_errors();
        test_backpressure();
        test_wrap_restart();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
